// File: rtl/result_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// result_buffer
//
// Result-side store for the tiled matrix multiplier. Holds the m x m output
// tile, serves the multiplier's read-modify-write through a zero-latency read
// port (current_element), accepts partial results on the z_stb/z_ack
// handshake, and streams the finished tile out row-major on a valid/ready
// port once the multiplier reports done.
//
// Parameters
//   m      tile dimension; the buffer holds m*m 32-bit entries
//   m_len  width of a row/column index
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active low
//   start            one-cycle pulse; clears the tile and opens collection
//   z_out/z_i/z_j    partial result and its row/column
//   z_stb / z_ack    write strobe (held until acked) / one-cycle acknowledge
//   current_element  combinational read of the entry at (z_i, z_j)
//   mul_done         multiplier finished; ends collection, starts the drain
//   out_data/out_i/out_j/out_valid/out_ready/out_last
//                    row-major drain stream; out_last marks (m-1, m-1)
//   busy             registered "not idle" flag
//   err              sticky protocol-error flag
//
// Build option
//   RESULT_BUFFER_ERR_EN  when defined, err latches on protocol misuse
//                         (strobe while idle/draining, start while busy,
//                         strobe and done together). Otherwise err is 0.
// -----------------------------------------------------------------------------
module result_buffer #(
  parameter int m     = 4,
  parameter int m_len = $clog2(m)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       z_out,
  input  logic [m_len-1:0]  z_i,
  input  logic [m_len-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  output logic [31:0]       current_element,
  input  logic              mul_done,
  output logic [31:0]       out_data,
  output logic [m_len-1:0]  out_i,
  output logic [m_len-1:0]  out_j,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int n_entries = m * m;
  localparam int idx_len   = $clog2(n_entries);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ACK,
    S_DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic [31:0]          mem_q [m][m];
  logic [31:0]          mem_d [m][m];
  logic                 z_ack_q,     z_ack_d;
  logic                 done_pend_q, done_pend_d;
  logic [idx_len-1:0]   idx_q,       idx_d;
  logic                 busy_q,      busy_d;

  // Row/column of the entry currently offered on the drain port.
  logic [m_len-1:0]     drain_i;
  logic [m_len-1:0]     drain_j;
  logic                 drain_at_end;

  assign drain_i      = m_len'(idx_q / idx_len'(m));
  assign drain_j      = m_len'(idx_q % idx_len'(m));
  assign drain_at_end = (idx_q == idx_len'(n_entries - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    mem_d       = mem_q;
    z_ack_d     = 1'b0;
    done_pend_d = done_pend_q;
    idx_d       = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < m; i++) begin
            for (int j = 0; j < m; j++) begin
              mem_d[i][j] = '0;
            end
          end
          done_pend_d = 1'b0;
          idx_d       = '0;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A strobe always wins; a mul_done in the same cycle is dropped.
        if (z_stb) begin
          mem_d[z_i][z_j] = z_out;
          z_ack_d         = 1'b1;
          state_d         = S_ACK;
        end else if (mul_done || done_pend_q) begin
          done_pend_d = 1'b0;
          idx_d       = '0;
          state_d     = S_DRAIN;
        end
      end

      S_ACK: begin
        // Wait here until the strobe is released so one strobe is exactly
        // one write. A done seen meanwhile is remembered for S_COLLECT.
        if (mul_done) begin
          done_pend_d = 1'b1;
        end
        if (!z_stb) begin
          state_d = S_COLLECT;
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (drain_at_end) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the tile storage is reset along with the control state, because a
  // reset must leave every entry reading back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      z_ack_q     <= 1'b0;
      done_pend_q <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < m; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      state_q     <= state_d;
      z_ack_q     <= z_ack_d;
      done_pend_q <= done_pend_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign z_ack           = z_ack_q;
  assign busy            = busy_q;
  assign current_element = mem_q[z_i][z_j];

  // The drain port is gated by the state so it reads all-zero whenever no
  // drain is in progress, including immediately on reset.
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid && drain_at_end;
  assign out_data  = out_valid ? mem_q[drain_i][drain_j] : '0;
  assign out_i     = out_valid ? drain_i : '0;
  assign out_j     = out_valid ? drain_j : '0;

  // ---------------------------------------------------------------------------
  // Protocol error flag
  // ---------------------------------------------------------------------------
`ifdef RESULT_BUFFER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    case (state_q)
      S_IDLE:    if (z_stb)                      err_d = 1'b1;
      S_COLLECT: if (start || (z_stb && mul_done)) err_d = 1'b1;
      S_ACK:     if (start)                      err_d = 1'b1;
      S_DRAIN:   if (start || z_stb)             err_d = 1'b1;
      default:   err_d = err_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/result_buffer.md
# result_buffer

Result-side store for the tiled matrix multiplier. It holds the m×m output tile and answers the multiplier's current-element read combinationally from the write index (z_i, z_j). It accepts each partial result on the z_stb/z_ack handshake. After the multiplier signals done, it streams the finished tile out row-major on a valid/ready port. It sits directly downstream of the row/column multiplier and feeds its current_element input.

## Interface
- m, 4: tile dimension; the buffer holds m*m entries.
- m_len, $clog2(m): index width.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- start  in  1  single-cycle pulse; zeroes the tile and begins collection. Honoured only in S_IDLE.
- z_out  in  32  partial result from the multiplier.
- z_i, z_j  in  m_len  row and column of z_out; also the read address for current_element.
- z_stb  in  1  z_out/z_i/z_j valid; held high until z_ack is seen.
- z_ack  out  1  registered one-cycle acknowledge.
- current_element  out  32  combinational mem[z_i][z_j].
- mul_done  in  1  multiplier done pulse; ends collection.
- out_data  out  32  drained entry.
- out_i, out_j  out  m_len  index of out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream ready.
- out_last  out  1  high with entry (m-1, m-1).
- busy  out  1  high in any state other than S_IDLE.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- Storage: m*m 32-bit registers mem[i][j]. Reset clears them to 0.
- States:
  - S_IDLE, S_COLLECT, S_ACK and S_DRAIN.
  - S_IDLE: when start=1, zero all entries in that edge and go to S_COLLECT. All other inputs are ignored.
  - S_COLLECT: when z_stb=1, write mem[z_i][z_j] <= z_out, set z_ack <= 1 and go to S_ACK. Otherwise, when mul_done=1, set drain index to 0 and go to S_DRAIN. If z_stb and mul_done are high in the same cycle, the write wins and mul_done is dropped; this is an error.
  - S_ACK: set z_ack <= 0. Stay in S_ACK while z_stb=1, which guarantees one write per strobe. Return to S_COLLECT when z_stb=0. A mul_done arriving in S_ACK is latched and acted on at the return to S_COLLECT.
  - S_DRAIN: out_valid=1. out_data=mem[idx/m][idx%m]. out_i=idx/m, out_j=idx%m. On out_valid&out_ready: if idx=m*m-1, go to S_IDLE; otherwise idx <= idx+1. out_data and index are held stable while out_ready=0.
- The same entry may be written any number of times; the last write wins. The multiplier performs read-modify-write through current_element.
- z_stb in S_IDLE or S_DRAIN: not acknowledged, no write.
- start outside S_IDLE: ignored.

## Timing
- Reset values: state=S_IDLE, z_ack=0, out_valid=0, out_last=0, out_data=0, out_i=0, out_j=0, busy=0, err=0, all entries 0.
- Reset asserted mid-operation: all of the above take effect immediately and asynchronously. Any in-flight write or drain is abandoned.
- current_element has zero latency and is a pure mux on (z_i, z_j).
- z_stb rising (in S_COLLECT) at edge N:
  - write is visible on current_element after edge N;
  - z_ack is high for exactly the cycle N..N+1;
  - the next write is accepted no earlier than 2 cycles after z_stb falls.
- mul_done to first out_valid: 1 cycle.
- Drain takes m*m accepted transfers. With out_ready held high, that is m*m cycles, then S_IDLE the following cycle.
- busy is registered from the state.

## Configuration
- RESULT_BUFFER_ERR_EN defined:
  - err is set and held until reset by any of:
    - z_stb=1 in S_IDLE or S_DRAIN;
    - start=1 outside S_IDLE;
    - z_stb and mul_done both high in S_COLLECT.
  - A latched mul_done in S_ACK is not an error.
- Not defined: err is tied to 0. The same events are silently ignored as described above.

## Test plan
- Reset then start; m=4; write z_out=0x3F800000 at (2,1) -> z_ack high for 1 cycle; current_element at (2,1)=0x3F800000; all other addresses read 0.
- Hold z_stb high for 5 cycles at (0,0) with 0x40000000 -> exactly one z_ack pulse, one write, state stays S_ACK until z_stb drops.
- Write 16 distinct values, mul_done, out_ready=1 -> out_valid 1 cycle after mul_done; 16 transfers row-major (0,0)..(3,3); out_last only on (3,3); busy drops after the 16th transfer.
- Drain with out_ready toggled 1,0,0,1 -> out_data/out_i/out_j held during the 0 cycles; no entry skipped or duplicated.
- Assert rst=0 during the drain at index 7 -> outputs and entries 0 immediately; after release, start and a fresh collect/drain work normally.
- With RESULT_BUFFER_ERR_EN: z_stb in S_IDLE -> no z_ack, err=1 and sticky until reset. Without the macro -> err stays 0.
